seq_divider_16bit: RTL



---
 rtl/seq_divider_16bit_pkg.sv | 20 ++
 rtl/seq_divider_16bit_if.sv | 23 ++
 rtl/seq_divider_16bit_div_step.sv | 27 ++
 rtl/seq_divider_16bit.sv | 110 +++++++++++
 4 files changed

// File: rtl/seq_divider_16bit_pkg.sv
// Shared constants for the iterative divider and the ALU result mux that consumes it.
package seq_divider_16bit_pkg;

  localparam int DEF_WIDTH = 16;

  // FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_t;

  // Quotient reported when the divisor is zero
  localparam logic [15:0] DIV_ZERO_Q = 16'hFFFF;

  // MUX16 select codes for the two results of one divide
  localparam logic [3:0] OP_DIV = 4'd11;
  localparam logic [3:0] OP_MOD = 4'd12;

endpackage

// File: rtl/seq_divider_16bit_if.sv
// Handshake and operand/result bundle between the ALU control and the divider.
interface seq_divider_16bit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             error;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, error
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, error
  );
endinterface

// File: rtl/seq_divider_16bit_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module seq_divider_16bit_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  // The partial remainder is always below the divisor, so its top bit is never set.
  logic           unused_rem_msb;

  assign unused_rem_msb = rem_in[WIDTH];

  // Trial subtraction on WIDTH+1 bits; the borrow-free case means rem >= divisor.
  always_comb begin
    shifted = {rem_in[WIDTH-1:0], dvd_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/seq_divider_16bit.sv
// Iterative restoring divider: one quotient bit per clock, results held for the ALU mux.
module seq_divider_16bit
  import seq_divider_16bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  seq_divider_16bit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic             accept;
  logic             last_step;

  // dvd_q shifts the dividend out at the MSB and collects quotient bits at the LSB,
  // so after WIDTH steps it holds the quotient.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remd_q;
  logic             err_q;

  logic [WIDTH:0]   rem_next;
  logic             q_bit;

  seq_divider_16bit_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; DONE accepts a new start just like IDLE for back-to-back ops.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = (bus.b == '0) ? DONE : RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == LAST_STEP) begin
          last_step = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in RUN, publish results only on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      remd_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      dvd_q <= bus.a;
      dvs_q <= bus.b;
      rem_q <= '0;
      cnt_q <= '0;
      if (bus.b == '0) begin
        err_q  <= 1'b1;
        quot_q <= WIDTH'(DIV_ZERO_Q);
        remd_q <= bus.a;
      end else begin
        err_q  <= 1'b0;
      end
    end else if (state_q == RUN) begin
      dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
      rem_q <= rem_next;
      cnt_q <= cnt_q + 1'b1;
      if (last_step) begin
        quot_q <= {dvd_q[WIDTH-2:0], q_bit};
        remd_q <= rem_next[WIDTH-1:0];
      end
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = remd_q;
  assign bus.error     = err_q;

endmodule
